// File: rtl/conv1d_param_engine.sv
// conv1d_param_engine: parametrised 1-D convolution engine with stride, optional ReLU and valid/ready streams
// Ports: clk_i clock; rst_ni async active-low reset;
//        x_data_i/x_valid_i/x_ready_o input-sample stream; f_data_i/f_valid_i/f_ready_o filter-tap stream;
//        y_data_o/y_valid_o/y_ready_i result stream; busy_o high while computing or presenting a result.
module conv1d_param_engine #(
  parameter int T = 10,
  parameter int M = 112,
  parameter int N = 49,
  parameter int S = 1,
  parameter int RELU = 0,
  localparam int OW = 2*T+$clog2(N)+1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic signed [T-1:0]  x_data_i,
  input  logic                 x_valid_i,
  output logic                 x_ready_o,
  input  logic signed [T-1:0]  f_data_i,
  input  logic                 f_valid_i,
  output logic                 f_ready_o,
  output logic signed [OW-1:0] y_data_o,
  output logic                 y_valid_o,
  input  logic                 y_ready_i,
  output logic                 busy_o
);
  localparam int P  = (M-N)/S+1;
  localparam int AW = $clog2(M);
  localparam int FA = $clog2(N);
  localparam int CW = $clog2(M+N+S+4);
  localparam logic [CW-1:0] M_C = CW'(M);
  localparam logic [CW-1:0] N_C = CW'(N);
  localparam logic [CW-1:0] S_C = CW'(S);
  localparam logic [CW-1:0] LAST_C = CW'(P-1);
  localparam logic [CW-1:0] ACC_LO = CW'(2);
  localparam logic [CW-1:0] ACC_HI = CW'(N+1);
  localparam logic [CW-1:0] DONE_C = CW'(N+2);
  typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] xcnt_q, xcnt_d, fcnt_q, fcnt_d, jc_q, jc_d, b_q, b_d, p_q, p_d;
  logic signed [OW-1:0] acc_q, acc_d, y_q, y_d;
  logic yv_q, yv_d, xrdy_q, xrdy_d, frdy_q, frdy_d;
  logic signed [T-1:0] x_mem [M];
  logic signed [T-1:0] f_mem [N];
  logic signed [T-1:0] xm_q, fm_q;
  logic signed [2*T-1:0] prod_q;
  logic x_fire, f_fire;
  logic [AW-1:0] xa;
  assign x_fire    = x_valid_i & xrdy_q;
  assign f_fire    = f_valid_i & frdy_q;
  assign xa        = AW'(b_q + jc_q);
  assign x_ready_o = xrdy_q;
  assign f_ready_o = frdy_q;
  assign y_data_o  = y_q;
  assign y_valid_o = yv_q;
  assign busy_o    = state_q != LOAD;
  // Memories and the read/multiply pipeline carry no reset; jc_q gates what reaches the accumulator.
  always_ff @(posedge clk_i) begin
    if (x_fire) x_mem[xcnt_q[AW-1:0]] <= x_data_i;
    if (f_fire) f_mem[fcnt_q[FA-1:0]] <= f_data_i;
    if (state_q == COMPUTE && jc_q < N_C) begin
      xm_q <= x_mem[xa];
      fm_q <= f_mem[jc_q[FA-1:0]];
    end
    prod_q <= (2*T)'(xm_q) * (2*T)'(fm_q);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= LOAD;
      xcnt_q  <= '0;
      fcnt_q  <= '0;
      jc_q    <= '0;
      b_q     <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      yv_q    <= 1'b0;
      xrdy_q  <= 1'b0;
      frdy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      xcnt_q  <= xcnt_d;
      fcnt_q  <= fcnt_d;
      jc_q    <= jc_d;
      b_q     <= b_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      yv_q    <= yv_d;
      xrdy_q  <= xrdy_d;
      frdy_q  <= frdy_d;
    end
  end
  // jc_q counts cycles inside a window: read j issues at jc=j, its product is summed at jc=j+2.
  always_comb begin
    state_d = state_q;
    xcnt_d  = xcnt_q;
    fcnt_d  = fcnt_q;
    jc_d    = jc_q;
    b_d     = b_q;
    p_d     = p_q;
    acc_d   = acc_q;
    y_d     = y_q;
    yv_d    = yv_q;
    case (state_q)
      LOAD: begin
        xcnt_d = xcnt_q + CW'(x_fire);
        fcnt_d = fcnt_q + CW'(f_fire);
        if (xcnt_d == M_C && fcnt_d == N_C) begin
          state_d = COMPUTE;
          jc_d    = '0;
          b_d     = '0;
          p_d     = '0;
        end
      end
      COMPUTE: begin
        jc_d  = jc_q + CW'(1);
        acc_d = (jc_q == '0) ? '0 : (jc_q >= ACC_LO && jc_q <= ACC_HI) ? acc_q + OW'(prod_q) : acc_q;
        if (jc_q == DONE_C) begin
          y_d     = (RELU != 0 && acc_q[OW-1]) ? '0 : acc_q;
          yv_d    = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (yv_q && y_ready_i) begin
          yv_d = 1'b0;
          if (p_q == LAST_C) begin
            state_d = LOAD;
            xcnt_d  = '0;
            fcnt_d  = '0;
            p_d     = '0;
            b_d     = '0;
          end else begin
            state_d = COMPUTE;
            jc_d    = '0;
            p_d     = p_q + CW'(1);
            b_d     = b_q + S_C;
          end
        end
      end
      default: state_d = LOAD;
    endcase
    xrdy_d = state_d == LOAD && xcnt_d < M_C;
    frdy_d = state_d == LOAD && fcnt_d < N_C;
  end
endmodule

// File: doc/conv1d_param_engine.md
Name: conv1d_param_engine

Overview:
- Parametrised 1-D convolution engine, next generation of the fixed-size conv blocks.
- Loads an M-sample input vector and an N-tap filter through independent valid/ready streams into internal sync-read memories.
- Produces P = floor((M-N)/S)+1 dot products, using configurable stride S and optional ReLU, through a valid/ready output with full backpressure.
- Pipelined MAC path (read, multiply, accumulate registered). Sits between the sample DMA front-end and the result collector.

Parameters:
- T, 10, signed width of x_data and f_data.
- M, 112, input vector length (M >= N >= 2).
- N, 49, filter length.
- S, 1, output stride (1 <= S <= M-N+1).
- RELU, 0, 1 = clamp negative results to 0 before output.
- OW, 2*T+$clog2(N)+1, y_data width (localparam, not overridable); no overflow is possible.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- x_data  in  T  signed input sample
- x_valid  in  1  x_data valid
- x_ready  out  1  engine accepts x
- f_data  in  T  signed filter tap
- f_valid  in  1  f_data valid
- f_ready  out  1  engine accepts f
- y_data  out  OW  signed result
- y_valid  out  1  result valid
- y_ready  in  1  downstream accepts y
- busy  out  1  high in COMPUTE/OUT states

Behaviour:
- Reset (reset=0, async) forces the following; memory contents are undefined and are not cleared.
  - state=LOAD; all counters and the accumulator are 0.
  - x_ready=0, f_ready=0, y_valid=0, y_data=0, busy=0.
- Handshake: a transfer occurs on a rising edge with valid&ready. y_data and y_valid are registered. While y_valid=1 and y_ready=0, y_data holds stable. y_valid never drops without a handshake.
- LOAD:
  - x_ready=1 until M samples have been accepted; f_ready=1 until N taps have been accepted. The two channels are independent and may transfer in the same cycle.
  - Sample k is written to x address k; tap j is written to f address j.
  - On the edge where both counts are complete, go to COMPUTE with window base b=0 and output index p=0. x_ready and f_ready are 0 in the cycle after.
- COMPUTE:
  - Issue N reads: x[b+j] and f[j] for j=0..N-1, one per cycle.
  - Memory data returns 1 cycle later. The product is registered 1 cycle after that. Accumulation happens into an OW-bit signed accumulator, which is cleared at the start of each window.
  - The last accumulate completes N+2 cycles after entering COMPUTE. The next cycle registers the result (with ReLU if RELU=1) into y_data, asserts y_valid, and enters OUT.
  - Latency: y_valid rises exactly N+3 cycles after the COMPUTE entry edge.
- OUT:
  - Wait for y_ready. On handshake, p<=p+1 and b<=b+S.
  - If p==P-1: go to LOAD, clear all counters, drop busy; a new vector and filter must be loaded.
  - Otherwise go to COMPUTE in the next cycle (no bubble beyond 1 cycle).
- Arithmetic: product is 2T-bit signed and sign-extended to OW before accumulating.
  - RELU=1: negative result -> 0.
  - RELU=0: raw two's-complement result.
- Boundaries:
  - x/f valid asserted outside LOAD or after its count is complete: ignored, no write, ready=0.
  - y_ready high while y_valid=0: no effect.
  - Last window start is b=(P-1)*S <= M-N; reads never exceed address M-1.
  - Reset asserted mid-COMPUTE or mid-OUT: immediate return to LOAD, y_valid=0 asynchronously, pending result discarded.
  - N==M: P=1.

Test Plan:
- M=8,N=3,S=1,T=10,RELU=0; x=1..8, f=1,1,1 loaded concurrently, y_ready=1 -> y=6,9,12,15,18,21; first y_valid 6 cycles after the last load edge; then x_ready and f_ready return to 1.
- Same vectors, S=2 -> y=6,12,18 (P=3), then back to LOAD.
- x=1..8, f=-1,-1,-1: RELU=0 -> y=-6,-9,...,-21; RELU=1 -> six results of 0.
- y_ready held low for 5 cycles on the second result -> y_data=9 stable with y_valid=1 throughout; accepted on the 6th cycle; the next result follows correctly.
- T=10, N=3, all x=-512 and f=-512 -> every y=786432 with no wrap; x valid with random gaps and f valid in bursts -> identical results.
- reset pulsed low mid-COMPUTE of output 2 -> y_valid=0 immediately, busy=0, x_ready=f_ready=1 after release; a full reload reproduces 6,9,12,15,18,21.
